fast_square_sweep_ctrl: RTL



---
 rtl/fast_square_sweep_ctrl_if.sv | 9 +
 rtl/fast_square_sweep_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fast_square_sweep_ctrl_if.sv
// Serial settings bus feeding the sweep sequencer's configuration registers.
interface fast_square_sweep_ctrl_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (output serial_addr, output serial_data, output serial_strobe);
  modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface

// File: rtl/fast_square_sweep_ctrl.sv
// Sweep sequencer for the fast-square receiver: record windows, freq_step
// pulses and inter-window gaps over a programmed number of frequency points.
module fast_square_sweep_ctrl #(
  parameter int CTRLADDR          = 3,
  parameter int STEPSADDR         = 4,
  parameter int GAPADDR           = 5,
  parameter int RECORD_TICKS_LOG2 = 14,
  parameter int MIN_GAP           = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  fast_square_sweep_ctrl_if.slave  sbus,
  input  logic                     trigger,
  output logic                     record,
  output logic                     freq_step,
  output logic                     busy,
  output logic [15:0]              step_index,
  output logic                     sweep_done
);

  localparam logic [6:0]  CTRL_A  = 7'(CTRLADDR);
  localparam logic [6:0]  STEPS_A = 7'(STEPSADDR);
  localparam logic [6:0]  GAP_A   = 7'(GAPADDR);
  localparam logic [15:0] MIN_G   = 16'(MIN_GAP);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RECORD, S_STEP, S_GAP, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [1:0]                     ctrl_q, ctrl_d;
  logic [15:0]                    steps_q, steps_d, gap_q, gap_d;
  logic [15:0]                    n_q, n_d, g_q, g_d;
  logic [15:0]                    step_q, step_d, gcnt_q, gcnt_d;
  logic [RECORD_TICKS_LOG2-1:0]   tick_q, tick_d;
  logic                           record_q, freq_step_q, busy_q, sweep_done_q;
  logic                           en, cont;
  logic [15:0]                    n_new, g_new;
  logic                           unused_data;

  assign unused_data = ^sbus.serial_data[31:16];

  // Settings write decode; the FSM looks at the post-write value so a write
  // (e.g. clearing enable) acts on the very next cycle.
  always_comb begin
    ctrl_d  = ctrl_q;
    steps_d = steps_q;
    gap_d   = gap_q;
    if (sbus.serial_strobe) begin
      if (sbus.serial_addr == CTRL_A)  ctrl_d  = sbus.serial_data[1:0];
      if (sbus.serial_addr == STEPS_A) steps_d = sbus.serial_data[15:0];
      if (sbus.serial_addr == GAP_A)   gap_d   = sbus.serial_data[15:0];
    end
  end

  // Settings registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q  <= '0;
      steps_q <= '0;
      gap_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      steps_q <= steps_d;
      gap_q   <= gap_d;
    end
  end

  assign en    = ctrl_d[0];
  assign cont  = ctrl_d[1];
  assign n_new = (steps_d == 16'd0) ? 16'd1 : steps_d;
  assign g_new = (gap_d < MIN_G) ? MIN_G : gap_d;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    tick_d  = '0;
    gcnt_d  = '0;
    step_d  = step_q;
    n_d     = n_q;
    g_d     = g_q;
    case (state_q)
      S_IDLE: if (en) state_d = S_ARM;
      S_ARM: begin
        if (!en) state_d = S_IDLE;
        else if (trigger) begin
          state_d = S_RECORD;
          step_d  = '0;
          n_d     = n_new;
          g_d     = g_new;
        end
      end
      S_RECORD: begin
        if (!en) state_d = S_IDLE;
        else begin
          tick_d = tick_q + 1'b1;
          if (tick_q == '1) state_d = S_STEP;
        end
      end
      S_STEP: begin
        // The freq_step for this window is already out, so the count advances.
        step_d = step_q + 16'd1;
        if (!en)                        state_d = S_IDLE;
        else if (step_q == n_q - 16'd1) state_d = S_DONE;
        else                            state_d = S_GAP;
      end
      S_GAP: begin
        if (!en) state_d = S_IDLE;
        else if (gcnt_q == g_q - 16'd1) state_d = S_RECORD;
        else gcnt_d = gcnt_q + 16'd1;
      end
      S_DONE: begin
        step_d = '0;
        if (!en) state_d = S_IDLE;
        else if (cont) begin
          // DONE stands in for the first gap cycle so back-to-back sweeps
          // keep the same step period as steps within a sweep.
          state_d = S_GAP;
          gcnt_d  = 16'd1;
          n_d     = n_new;
          g_d     = g_new;
        end else state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs (decoded from next state so they
  // line up with the state register).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      gcnt_q       <= '0;
      step_q       <= '0;
      n_q          <= '0;
      g_q          <= '0;
      record_q     <= 1'b0;
      freq_step_q  <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      gcnt_q       <= gcnt_d;
      step_q       <= step_d;
      n_q          <= n_d;
      g_q          <= g_d;
      record_q     <= (state_d == S_RECORD);
      freq_step_q  <= (state_d == S_STEP);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_ARM);
      sweep_done_q <= (state_d == S_DONE);
    end
  end

  assign record     = record_q;
  assign freq_step  = freq_step_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign step_index = step_q;

endmodule
